// File: rtl/id_exe_hazard_ctrl.sv
// rtl/id_exe_hazard_ctrl.sv - ID/EXE sequencing: load-use stall, FP hold, branch flush, stall counter
// Outputs are combinational from state and inputs so hazards are answered in the same cycle.
module id_exe_hazard_ctrl #(
  parameter int FP_LATENCY = 4,
  parameter int STALL_W    = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               valid_ID,
  input  logic               FP_ID,
  input  logic [4:0]         Rs_ID,
  input  logic [4:0]         Rt_ID,
  input  logic               uses_rs_ID,
  input  logic               uses_rt_ID,
  input  logic               MemRead_EXE,
  input  logic               RegWrite_EXE,
  input  logic [4:0]         Dst_EXE,
  input  logic               branch_taken_EXE,
  output logic               PC_write,
  output logic               IFID_write,
  output logic               IFID_flush,
  output logic               IDEXE_write,
  output logic               IDEXE_bubble,
  output logic               fp_busy,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] FP_BUSY = 1'b1;

  localparam logic [2:0]         FP_CNT_INIT = 3'(FP_LATENCY - 1);
  localparam logic [STALL_W-1:0] STALL_ONE   = {{(STALL_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic [2:0] fp_cnt;
  logic       load_use;
  logic       fp_issue;

  assign load_use = MemRead_EXE & RegWrite_EXE & (Dst_EXE != 5'd0) & valid_ID &
                    ((uses_rs_ID & (Rs_ID == Dst_EXE)) | (uses_rt_ID & (Rt_ID == Dst_EXE)));

  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEXE_write  = 1'b1;
    IDEXE_bubble = 1'b0;
    if (!Rst_n) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IFID_flush   = 1'b1;
      IDEXE_write  = 1'b0;
      IDEXE_bubble = 1'b1;
    end else if (state == FP_BUSY) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEXE_write = 1'b0;
    end else if (branch_taken_EXE) begin
      IFID_flush   = 1'b1;
      IDEXE_bubble = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEXE_bubble = 1'b1;
    end
  end

  // An FP op only issues when it really lands in ID/EXE, never as a bubble.
  assign fp_issue = (state == RUN) & valid_ID & FP_ID & IDEXE_write & ~IDEXE_bubble;
  assign fp_busy  = Rst_n & (state == FP_BUSY);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= RUN;
      fp_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (fp_issue && (FP_LATENCY > 1)) begin
            state  <= FP_BUSY;
            fp_cnt <= FP_CNT_INIT;
          end
        end
        default: begin
          if (fp_cnt == 3'd1) begin
            state  <= RUN;
            fp_cnt <= 3'd0;
          end else begin
            fp_cnt <= fp_cnt - 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_count <= '0;
    end else if (!PC_write && (stall_count != {STALL_W{1'b1}})) begin
      stall_count <= stall_count + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// tb/tb_id_exe_hazard_ctrl.sv - directed and randomized check of id_exe_hazard_ctrl against a cycle model
module tb_id_exe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int SW  = 4;
  localparam int SAT = (1 << SW) - 1;

  logic          Clk;
  logic          Rst_n;
  logic          valid_ID, FP_ID, uses_rs_ID, uses_rt_ID;
  logic [4:0]    Rs_ID, Rt_ID, Dst_EXE;
  logic          MemRead_EXE, RegWrite_EXE, branch_taken_EXE;
  logic          PC_write, IFID_write, IFID_flush, IDEXE_write, IDEXE_bubble, fp_busy;
  logic [SW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  int hold_left = 0;
  int stalls    = 0;
  logic e_pc, e_ifw, e_fl, e_idw, e_bub, e_busy, e_issue;

  id_exe_hazard_ctrl #(.FP_LATENCY(LAT), .STALL_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .valid_ID(valid_ID), .FP_ID(FP_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EXE(MemRead_EXE), .RegWrite_EXE(RegWrite_EXE), .Dst_EXE(Dst_EXE),
    .branch_taken_EXE(branch_taken_EXE),
    .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .IDEXE_write(IDEXE_write), .IDEXE_bubble(IDEXE_bubble), .fp_busy(fp_busy),
    .stall_count(stall_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hazard_match();
    bit src_hit;
    src_hit = (uses_rs_ID && Rs_ID == Dst_EXE) || (uses_rt_ID && Rt_ID == Dst_EXE);
    return MemRead_EXE && RegWrite_EXE && Dst_EXE != 0 && valid_ID && src_hit;
  endfunction

  // Inputs are already driven; predict, compare, then advance the model across one rising edge.
  task automatic run_cycle();
    bit lu;
    if (!Rst_n) begin
      hold_left = 0;
      stalls    = 0;
    end
    lu = hazard_match();
    e_issue = 1'b0;
    if (!Rst_n) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00101;
    end else if (hold_left > 0) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00000;
    end else if (branch_taken_EXE) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11111;
    end else if (lu) begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00011;
    end else begin
      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11010;
      e_issue = valid_ID && FP_ID;
    end
    e_busy = Rst_n && hold_left > 0;
    #1;
    chk("PC_write", PC_write, e_pc);
    chk("IFID_write", IFID_write, e_ifw);
    chk("IFID_flush", IFID_flush, e_fl);
    chk("IDEXE_write", IDEXE_write, e_idw);
    chk("IDEXE_bubble", IDEXE_bubble, e_bub);
    chk("fp_busy", fp_busy, e_busy);
    chk("stall_count", stall_count, stalls);
    if (!Rst_n) chk("fp_cnt_rst", dut.fp_cnt, 0);
    @(posedge Clk);
    if (Rst_n) begin
      if (!e_pc && stalls < SAT) stalls++;
      if (hold_left > 0) hold_left--;
      else if (e_issue && LAT > 1) hold_left = LAT - 1;
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    valid_ID = 0; FP_ID = 0; Rs_ID = 0; Rt_ID = 0; uses_rs_ID = 0; uses_rt_ID = 0;
    MemRead_EXE = 0; RegWrite_EXE = 0; Dst_EXE = 0; branch_taken_EXE = 0;
  endtask

  task automatic set_load_use(input logic [4:0] dst);
    idle_inputs();
    valid_ID = 1; MemRead_EXE = 1; RegWrite_EXE = 1; Dst_EXE = dst; Rs_ID = 8; uses_rs_ID = 1;
  endtask

  initial begin
    idle_inputs();
    Rst_n = 0;
    repeat (3) run_cycle();
    Rst_n = 1;
    run_cycle();

    set_load_use(5'd8);
    run_cycle();
    chk("lu_stall_count", stall_count, 1);
    MemRead_EXE = 0;
    run_cycle();
    set_load_use(5'd0);
    run_cycle();
    chk("lu_dst0_count", stall_count, 1);

    idle_inputs();
    valid_ID = 1; FP_ID = 1;
    run_cycle();
    chk("fp_enter", fp_busy, 1);
    FP_ID = 0;
    repeat (3) run_cycle();
    chk("fp_exit", fp_busy, 0);
    chk("fp_stalls", stall_count, 4);

    valid_ID = 1; FP_ID = 1;
    repeat (8) run_cycle();

    idle_inputs();
    repeat (3) run_cycle();
    set_load_use(5'd8);
    FP_ID = 1; branch_taken_EXE = 1;
    run_cycle();
    chk("branch_no_fp", fp_busy, 0);
    chk("branch_no_stall", stall_count, stalls);

    idle_inputs();
    valid_ID = 1; FP_ID = 1;
    run_cycle();
    FP_ID = 0;
    run_cycle();
    Rst_n = 0;
    run_cycle();
    chk("mid_fp_busy", fp_busy, 0);
    chk("mid_fp_count", stall_count, 0);
    Rst_n = 1;

    set_load_use(5'd8);
    repeat (20) run_cycle();
    chk("saturate", stall_count, SAT);

    for (int i = 0; i < 2000; i++) begin
      Rst_n            = ($urandom_range(0, 40) != 0);
      valid_ID         = ($urandom_range(0, 5) != 0);
      FP_ID            = ($urandom_range(0, 5) == 0);
      Rs_ID            = 5'($urandom_range(0, 3));
      Rt_ID            = 5'($urandom_range(0, 3));
      uses_rs_ID       = 1'($urandom);
      uses_rt_ID       = 1'($urandom);
      MemRead_EXE      = ($urandom_range(0, 2) == 0);
      RegWrite_EXE     = ($urandom_range(0, 3) != 0);
      Dst_EXE          = 5'($urandom_range(0, 3));
      branch_taken_EXE = ($urandom_range(0, 7) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_hazard_ctrl.md
# id_exe_hazard_ctrl

Pipeline sequencing controller for the ID/EXE boundary of the MIPS core. It detects load-use hazards, holds the pipeline while a multi-cycle FP operation occupies EXE, and flushes/bubbles on branch or jump resolution in EXE. It drives the PC, IF/ID and ID/EXE write enables and the ID/EXE bubble (control-zero) select. It keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- FP_LATENCY, 4, total EXE cycles of an FP op (legal range 1..8)
- STALL_W, 16, width of stall_count

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- valid_ID  in  1  ID holds a real instruction
- FP_ID  in  1  instruction in ID is a multi-cycle FP op
- Rs_ID, Rt_ID  in  5  source register numbers in ID
- uses_rs_ID, uses_rt_ID  in  1  instruction in ID reads Rs / Rt
- MemRead_EXE  in  1  instruction in EXE is a load
- RegWrite_EXE  in  1  instruction in EXE writes a register
- Dst_EXE  in  5  destination register of instruction in EXE
- branch_taken_EXE  in  1  branch/jump in EXE resolved taken
- PC_write  out  1  PC update enable
- IFID_write  out  1  IF/ID register enable
- IFID_flush  out  1  clear IF/ID to NOP
- IDEXE_write  out  1  ID/EXE register enable
- IDEXE_bubble  out  1  load all-zero control into ID/EXE instead of control_signal
- fp_busy  out  1  FSM in FP_BUSY
- stall_count  out  STALL_W  cycles with PC_write=0, saturating

## Operation
- FSM states: RUN, FP_BUSY; down-counter fp_cnt (3 bits).
- Outputs are combinational from state and inputs (same-cycle hazard response).
- load_use = MemRead_EXE & RegWrite_EXE & (Dst_EXE != 0) & valid_ID & ((uses_rs_ID & Rs_ID==Dst_EXE) | (uses_rt_ID & Rt_ID==Dst_EXE)).
- RUN, priority order:
  - branch_taken_EXE: PC_write=1, IFID_write=1, IFID_flush=1, IDEXE_write=1, IDEXE_bubble=1. load_use ignored.
  - else load_use: PC_write=0, IFID_write=0, IFID_flush=0, IDEXE_write=1, IDEXE_bubble=1.
  - else: all enables 1, IFID_flush=0, IDEXE_bubble=0.
- FP issue = RUN & valid_ID & FP_ID & IDEXE_write & !IDEXE_bubble. If FP_LATENCY>1: next state FP_BUSY, fp_cnt <= FP_LATENCY-1. If FP_LATENCY==1: stay RUN.
- FP_BUSY: PC_write=0, IFID_write=0, IDEXE_write=0, IDEXE_bubble=0, IFID_flush=0; all hazard/branch inputs ignored. fp_cnt decrements each edge; at fp_cnt==1 next state RUN, fp_cnt <= 0.
- stall_count increments on each edge where PC_write==0 and Rst_n high; holds at 2^STALL_W-1.
- Rst_n low (async): state RUN, fp_cnt 0, stall_count 0; outputs forced PC_write=0, IFID_write=0, IDEXE_write=0, IFID_flush=1, IDEXE_bubble=1, fp_busy=0. Reset mid-FP_BUSY aborts the hold immediately.

## Timing
- Load-use stall: exactly 1 cycle; next cycle the bubble is in EXE and load_use deasserts naturally.
- Branch flush: same cycle as branch_taken_EXE; 2 instructions killed (IF/ID, ID/EXE).
- FP op captured into ID/EXE at edge k: upstream held for FP_LATENCY-1 cycles (edges k+1..k+FP_LATENCY-1 hold); first RUN cycle after FP_BUSY is the op's last EXE cycle, op leaves at next edge.
- FP op in ID with concurrent branch or load_use: not issued (bubble), no FP_BUSY entry.
- Back-to-back FP ops: second enters FP_BUSY on the edge the first leaves EXE; no gap cycle.
- Rst_n deassertion: first RUN cycle on the first Clk edge after release.

## Test plan
- Reset: hold Rst_n=0 3 cycles -> PC_write=0, IFID_flush=1, IDEXE_bubble=1, stall_count=0; release -> all enables 1, bubble 0.
- Load-use: MemRead_EXE=1, RegWrite_EXE=1, Dst_EXE=8, Rs_ID=8, uses_rs_ID=1 -> one cycle PC_write=0, IFID_write=0, IDEXE_bubble=1; stall_count=1. Repeat with Dst_EXE=0 -> no stall.
- FP hold: FP_LATENCY=4, issue FP op -> fp_busy=1 for 3 cycles, IDEXE_write=0 those cycles, then RUN; stall_count=3.
- Branch vs load-use: both asserted -> IFID_flush=1, IDEXE_bubble=1, PC_write=1, stall_count unchanged; FP_ID=1 in ID same cycle -> no FP_BUSY entry.
- Reset mid-FP_BUSY: pull Rst_n low at fp_cnt=2 -> fp_busy=0 immediately, fp_cnt=0, stall_count=0.
- Saturation: STALL_W=4, 20 consecutive load-use cycles -> stall_count stops at 15.
